// File: rtl/iq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iq_pkg
// Description : Issue-queue widths, entry-word field positions and the
//               wakeup tag-match helper shared by ALU/LS queues and select.
// Revision    : 1.0 - initial release
// ============================================================================
package iq_pkg;
    localparam int IQ_DEPTH = 7;
    localparam int TAG_W    = 5;
    localparam int ENT_W    = 21;
    localparam int SEL_W    = 3;
    localparam int WAKE_N   = 4;

    localparam int ISSUED_B = 0;
    localparam int VALID_B  = 1;
    localparam int PRD_LSB  = 2;
    localparam int RS2RDY_B = 7;
    localparam int PRS2_LSB = 8;
    localparam int RS1RDY_B = 14;
    localparam int PRS1_LSB = 15;

    localparam logic [SEL_W-1:0] SEL_NONE = 3'd7;

    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [ENT_W-1:0] entry_t;

    function automatic logic tag_hit(
        input tag_t                         tag,
        input logic [WAKE_N-1:0]            en,
        input logic [WAKE_N-1:0][TAG_W-1:0] tags
    );
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < WAKE_N; k++) begin
            if (en[k] && (tags[k] == tag)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction
endpackage
`default_nettype wire

// File: rtl/iq_slot.sv
`default_nettype none
// ============================================================================
// Module      : iq_slot
// Description : One issue-queue slot: entry register, wakeup compare,
//               issue marking and release one cycle after issue.
// Revision    : 1.0 - initial release
// ============================================================================
module iq_slot
    import iq_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_flush,
    input  logic                         i_alloc,
    input  logic [ENT_W-1:0]             i_alloc_word,
    input  logic [WAKE_N-1:0]            i_wake_en,
    input  logic [WAKE_N-1:0][TAG_W-1:0] i_wake_tag,
    input  logic                         i_grant,
    output logic [ENT_W-1:0]             o_word
);
    logic [ENT_W-1:0] r_word_q;
    logic [ENT_W-1:0] w_word_d;
    logic [ENT_W-1:0] w_src;
    logic             w_valid;
    logic             w_issued;
    logic             w_rs1_hit;
    logic             w_rs2_hit;

    assign w_valid  = r_word_q[VALID_B];
    assign w_issued = r_word_q[ISSUED_B];

    // An occupied slot compares its stored sources; a free slot compares the
    // incoming dispatch so same-cycle broadcasts are not lost.
    assign w_src     = w_valid ? r_word_q : i_alloc_word;
    assign w_rs1_hit = tag_hit(w_src[PRS1_LSB +: TAG_W], i_wake_en, i_wake_tag);
    assign w_rs2_hit = tag_hit(w_src[PRS2_LSB +: TAG_W], i_wake_en, i_wake_tag);

    always_comb begin
        w_word_d = r_word_q;
        if (i_flush) begin
            w_word_d = '0;
        end else if (w_valid && w_issued) begin
            w_word_d = '0;
        end else if (w_valid) begin
            w_word_d[RS1RDY_B] = r_word_q[RS1RDY_B] | w_rs1_hit;
            w_word_d[RS2RDY_B] = r_word_q[RS2RDY_B] | w_rs2_hit;
            if (i_grant) begin
                w_word_d[ISSUED_B] = 1'b1;
            end
        end else if (i_alloc) begin
            w_word_d           = i_alloc_word;
            w_word_d[VALID_B]  = 1'b1;
            w_word_d[ISSUED_B] = 1'b0;
            w_word_d[RS1RDY_B] = i_alloc_word[RS1RDY_B] | w_rs1_hit;
            w_word_d[RS2RDY_B] = i_alloc_word[RS2RDY_B] | w_rs2_hit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word_q <= '0;
        end else begin
            r_word_q <= w_word_d;
        end
    end

    assign o_word = r_word_q;
endmodule
`default_nettype wire

// File: rtl/iq_alu_queue.sv
`default_nettype none
// ============================================================================
// Module      : iq_alu_queue
// Description : 7-entry ALU issue queue: two-lane dispatch allocator, result
//               tag wakeup, two-grant issue with delayed slot release.
// Revision    : 1.0 - initial release
// ============================================================================
module iq_alu_queue
    import iq_pkg::*;
#(
    parameter bit ASSERT_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             disp_en0,
    input  logic             disp_en1,
    input  logic [ENT_W-1:0] disp_entry0,
    input  logic [ENT_W-1:0] disp_entry1,
    output logic             disp_ready,
    output logic [2:0]       free_count,
    input  logic             wakeup_en0,
    input  logic             wakeup_en1,
    input  logic             wakeup_en2,
    input  logic             wakeup_en3,
    input  logic [TAG_W-1:0] wakeup_tag0,
    input  logic [TAG_W-1:0] wakeup_tag1,
    input  logic [TAG_W-1:0] wakeup_tag2,
    input  logic [TAG_W-1:0] wakeup_tag3,
    input  logic             sel_en0,
    input  logic             sel_en1,
    input  logic [SEL_W-1:0] sel_num0,
    input  logic [SEL_W-1:0] sel_num1,
    output logic [ENT_W-1:0] IQ_ALU_dout0,
    output logic [ENT_W-1:0] IQ_ALU_dout1,
    output logic [ENT_W-1:0] IQ_ALU_dout2,
    output logic [ENT_W-1:0] IQ_ALU_dout3,
    output logic [ENT_W-1:0] IQ_ALU_dout4,
    output logic [ENT_W-1:0] IQ_ALU_dout5,
    output logic [ENT_W-1:0] IQ_ALU_dout6
);
    logic [IQ_DEPTH-1:0][ENT_W-1:0] w_dout;
    logic [IQ_DEPTH-1:0][ENT_W-1:0] w_alloc_word;
    logic [IQ_DEPTH-1:0]            w_free;
    logic [IQ_DEPTH-1:0]            w_open;
    logic [IQ_DEPTH-1:0]            w_alloc;
    logic [IQ_DEPTH-1:0]            w_grant;
    logic [WAKE_N-1:0]              w_wake_en;
    logic [WAKE_N-1:0][TAG_W-1:0]   w_wake_tag;
    logic [SEL_W-1:0]               w_first;
    logic [SEL_W-1:0]               w_second;
    logic [SEL_W-1:0]               w_lane1_slot;
    logic [2:0]                     w_free_cnt;
    logic                           w_disp_ok;
    logic                           w_sel_conflict;

    assign w_wake_en  = {wakeup_en3, wakeup_en2, wakeup_en1, wakeup_en0};
    assign w_wake_tag = {wakeup_tag3, wakeup_tag2, wakeup_tag1, wakeup_tag0};

    // Walking from the top down leaves the two lowest free indices behind.
    always_comb begin
        w_first    = SEL_NONE;
        w_second   = SEL_NONE;
        w_free_cnt = 3'd0;
        for (int i = IQ_DEPTH - 1; i >= 0; i--) begin
            if (w_free[i]) begin
                w_second   = w_first;
                w_first    = SEL_W'(i);
                w_free_cnt = w_free_cnt + 3'd1;
            end
        end
    end

    assign free_count   = w_free_cnt;
    assign disp_ready   = (w_free_cnt >= 3'd2);
    assign w_disp_ok    = disp_ready;
    assign w_lane1_slot = disp_en0 ? w_second : w_first;

    always_comb begin
        w_alloc      = '0;
        w_alloc_word = '0;
        for (int i = 0; i < IQ_DEPTH; i++) begin
            if (w_disp_ok && disp_en0 && (w_first == SEL_W'(i))) begin
                w_alloc[i]      = 1'b1;
                w_alloc_word[i] = disp_entry0;
            end else if (w_disp_ok && disp_en1 && (w_lane1_slot == SEL_W'(i))) begin
                w_alloc[i]      = 1'b1;
                w_alloc_word[i] = disp_entry1;
            end
        end
    end

    // Duplicate grants are dropped together; stale grants die in the slot.
    assign w_sel_conflict = sel_en0 && sel_en1 && (sel_num0 == sel_num1);

    always_comb begin
        w_grant = '0;
        for (int i = 0; i < IQ_DEPTH; i++) begin
            w_grant[i] = !w_sel_conflict &&
                         ((sel_en0 && (sel_num0 == SEL_W'(i))) ||
                          (sel_en1 && (sel_num1 == SEL_W'(i))));
        end
    end

    for (genvar g = 0; g < IQ_DEPTH; g++) begin : g_slot
        iq_slot u_slot (
            .clk          (clk),
            .rst          (rst),
            .i_flush      (flush),
            .i_alloc      (w_alloc[g]),
            .i_alloc_word (w_alloc_word[g]),
            .i_wake_en    (w_wake_en),
            .i_wake_tag   (w_wake_tag),
            .i_grant      (w_grant[g]),
            .o_word       (w_dout[g])
        );
        assign w_free[g] = !w_dout[g][VALID_B];
        assign w_open[g] = w_dout[g][VALID_B] && !w_dout[g][ISSUED_B];
    end

    assign IQ_ALU_dout0 = w_dout[0];
    assign IQ_ALU_dout1 = w_dout[1];
    assign IQ_ALU_dout2 = w_dout[2];
    assign IQ_ALU_dout3 = w_dout[3];
    assign IQ_ALU_dout4 = w_dout[4];
    assign IQ_ALU_dout5 = w_dout[5];
    assign IQ_ALU_dout6 = w_dout[6];

    logic [7:0] w_open_ext;
    assign w_open_ext = {1'b0, w_open};

    always @(posedge clk) begin
        if (ASSERT_EN && !rst && !flush) begin
            a_disp_full: assert (!((disp_en0 || disp_en1) && !disp_ready))
                else $error("iq_alu_queue: dispatch with disp_ready low");
            a_sel_dup: assert (!w_sel_conflict)
                else $error("iq_alu_queue: both grants name the same slot");
            a_sel0_slot: assert (!sel_en0 || w_open_ext[sel_num0])
                else $error("iq_alu_queue: grant0 to a non-waiting slot");
            a_sel1_slot: assert (!sel_en1 || w_open_ext[sel_num1])
                else $error("iq_alu_queue: grant1 to a non-waiting slot");
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_iq_alu_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_iq_alu_queue
// Description : Directed vector table, hand sequences and random traffic
//               for iq_alu_queue against a slot-array reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iq_alu_queue;
    logic        clk = 1'b0;
    logic        rst, flush, disp_en0, disp_en1, sel_en0, sel_en1;
    logic [20:0] disp_entry0, disp_entry1;
    logic [3:0]  wen;
    logic [4:0]  wtag [4];
    logic [2:0]  sel_num0, sel_num1;
    logic        disp_ready;
    logic [2:0]  free_count;
    logic [20:0] dq0, dq1, dq2, dq3, dq4, dq5, dq6;

    int errors = 0;
    int checks = 0;

    logic        mvalid [7];
    logic        missued[7];
    logic [20:0] mword  [7];

    always #5 clk = ~clk;

    iq_alu_queue #(.ASSERT_EN(1'b0)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_en0(disp_en0), .disp_en1(disp_en1),
        .disp_entry0(disp_entry0), .disp_entry1(disp_entry1),
        .disp_ready(disp_ready), .free_count(free_count),
        .wakeup_en0(wen[0]), .wakeup_en1(wen[1]), .wakeup_en2(wen[2]), .wakeup_en3(wen[3]),
        .wakeup_tag0(wtag[0]), .wakeup_tag1(wtag[1]), .wakeup_tag2(wtag[2]), .wakeup_tag3(wtag[3]),
        .sel_en0(sel_en0), .sel_en1(sel_en1), .sel_num0(sel_num0), .sel_num1(sel_num1),
        .IQ_ALU_dout0(dq0), .IQ_ALU_dout1(dq1), .IQ_ALU_dout2(dq2), .IQ_ALU_dout3(dq3),
        .IQ_ALU_dout4(dq4), .IQ_ALU_dout5(dq5), .IQ_ALU_dout6(dq6)
    );

    function automatic logic [20:0] dout_of(input int i);
        case (i)
            0: return dq0;
            1: return dq1;
            2: return dq2;
            3: return dq3;
            4: return dq4;
            5: return dq5;
            default: return dq6;
        endcase
    endfunction

    function automatic logic [20:0] mk(input int prs1, input bit r1, input int prs2,
                                       input bit r2, input int prd, input bit v, input bit iss);
        return {1'b0, 5'(prs1), r1, 1'b0, 5'(prs2), r2, 5'(prd), v, iss};
    endfunction

    function automatic bit hit(input logic [4:0] tag);
        for (int k = 0; k < 4; k++) if (wen[k] && wtag[k] == tag) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: slots as plain arrays, free list as a queue of indices.
    task automatic model_step();
        int free_q[$];
        bit g0, g1;
        if (rst || flush) begin
            for (int i = 0; i < 7; i++) begin
                mvalid[i] = 0; missued[i] = 0; mword[i] = '0;
            end
            return;
        end
        for (int i = 0; i < 7; i++) if (!mvalid[i]) free_q.push_back(i);
        g0 = sel_en0 && !(sel_en1 && sel_num1 == sel_num0);
        g1 = sel_en1 && !(sel_en0 && sel_num1 == sel_num0);
        for (int i = 0; i < 7; i++) begin
            if (!mvalid[i]) continue;
            if (missued[i]) begin
                mvalid[i] = 0; missued[i] = 0; mword[i] = '0;
            end else begin
                if (hit(mword[i][19:15])) mword[i][14] = 1'b1;
                if (hit(mword[i][12:8]))  mword[i][7]  = 1'b1;
                if ((g0 && int'(sel_num0) == i) || (g1 && int'(sel_num1) == i)) begin
                    missued[i] = 1; mword[i][0] = 1'b1;
                end
            end
        end
        if (free_q.size() >= 2) begin
            if (disp_en0) begin
                int s = free_q.pop_front();
                mvalid[s] = 1; missued[s] = 0; mword[s] = disp_entry0;
                mword[s][1] = 1'b1; mword[s][0] = 1'b0;
                if (hit(disp_entry0[19:15])) mword[s][14] = 1'b1;
                if (hit(disp_entry0[12:8]))  mword[s][7]  = 1'b1;
            end
            if (disp_en1) begin
                int s = free_q.pop_front();
                mvalid[s] = 1; missued[s] = 0; mword[s] = disp_entry1;
                mword[s][1] = 1'b1; mword[s][0] = 1'b0;
                if (hit(disp_entry1[19:15])) mword[s][14] = 1'b1;
                if (hit(disp_entry1[12:8]))  mword[s][7]  = 1'b1;
            end
        end
    endtask

    task automatic check_model();
        int nf = 0;
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("model_dout%0d", i), 32'(dout_of(i)), 32'(mvalid[i] ? mword[i] : 21'd0));
            if (!mvalid[i]) nf++;
        end
        chk("model_free_count", 32'(free_count), 32'(nf));
        chk("model_disp_ready", 32'(disp_ready), 32'(nf >= 2));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic idle();
        rst = 0; flush = 0; disp_en0 = 0; disp_en1 = 0;
        disp_entry0 = '0; disp_entry1 = '0; wen = '0;
        for (int k = 0; k < 4; k++) wtag[k] = '0;
        sel_en0 = 0; sel_en1 = 0; sel_num0 = 3'd7; sel_num1 = 3'd7;
    endtask

    typedef struct {
        bit               rst, flush, en0, en1;
        logic [20:0]      e0, e1;
        logic [3:0]       wen;
        logic [3:0][4:0]  wt;
        bit               s0, s1;
        logic [2:0]       n0, n1;
        int               slot;
        logic [20:0]      exp_word;
        logic [2:0]       exp_free;
        bit               exp_ready;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t blank();
        vec_t v;
        v = '{rst: 0, flush: 0, en0: 0, en1: 0, e0: '0, e1: '0, wen: '0, wt: '0,
              s0: 0, s1: 0, n0: 3'd7, n1: 3'd7, slot: 0, exp_word: '0,
              exp_free: 3'd7, exp_ready: 1};
        return v;
    endfunction

    logic [20:0] resv_word;

    initial begin
        vec_t v;
        for (int i = 0; i < 7; i++) begin mvalid[i] = 0; missued[i] = 0; mword[i] = '0; end
        idle();
        resv_word = mk(5, 1, 6, 0, 11, 1, 1);
        resv_word[20] = 1'b1; resv_word[13] = 1'b1;

        // reset
        v = blank(); v.rst = 1; tbl.push_back(v);
        // dispatch with same-cycle forwarding on prs2
        v = blank(); v.en0 = 1; v.e0 = mk(3, 0, 4, 0, 9, 0, 0); v.wen = 4'b0100; v.wt[2] = 5'd4;
        v.exp_word = mk(3, 0, 4, 1, 9, 1, 0); v.exp_free = 6; tbl.push_back(v);
        // later wakeup of prs1
        v = blank(); v.wen = 4'b0001; v.wt[0] = 5'd3;
        v.exp_word = mk(3, 1, 4, 1, 9, 1, 0); v.exp_free = 6; tbl.push_back(v);
        // dual dispatch; lane1 carries reserved bits and junk in [1:0]
        v = blank(); v.en0 = 1; v.en1 = 1; v.e0 = mk(1, 0, 2, 0, 10, 0, 0); v.e1 = resv_word;
        v.slot = 2; v.exp_word = resv_word & ~21'h1; v.exp_free = 4; tbl.push_back(v);
        v = blank(); v.en0 = 1; v.e0 = mk(7, 0, 8, 0, 12, 0, 0);
        v.slot = 3; v.exp_word = mk(7, 0, 8, 0, 12, 1, 0); v.exp_free = 3; tbl.push_back(v);
        // dual grant: issued visible, still occupied
        v = blank(); v.s0 = 1; v.n0 = 3'd1; v.s1 = 1; v.n1 = 3'd3;
        v.slot = 1; v.exp_word = mk(1, 0, 2, 0, 10, 1, 1); v.exp_free = 3; tbl.push_back(v);
        // release
        v = blank(); v.slot = 3; v.exp_word = '0; v.exp_free = 5; tbl.push_back(v);
        // reuse: lowest free is slot 1
        v = blank(); v.en0 = 1; v.e0 = mk(9, 0, 9, 0, 13, 0, 0);
        v.slot = 1; v.exp_word = mk(9, 0, 9, 0, 13, 1, 0); v.exp_free = 4; tbl.push_back(v);
        v = blank(); v.s0 = 1; v.n0 = 3'd0;
        v.slot = 0; v.exp_word = mk(3, 1, 4, 1, 9, 1, 1); v.exp_free = 4; tbl.push_back(v);
        v = blank(); v.slot = 0; v.exp_word = '0; v.exp_free = 5; tbl.push_back(v);
        // lane1 alone takes the lowest free slot
        v = blank(); v.en1 = 1; v.e1 = mk(2, 0, 3, 0, 14, 0, 0);
        v.slot = 0; v.exp_word = mk(2, 0, 3, 0, 14, 1, 0); v.exp_free = 4; tbl.push_back(v);
        // flush beats everything
        v = blank(); v.flush = 1; v.en0 = 1; v.e0 = mk(1, 0, 1, 0, 1, 0, 0); v.wen = 4'b1111;
        v.wt[0] = 5'd2; v.s0 = 1; v.n0 = 3'd0; v.slot = 0; v.exp_free = 7; tbl.push_back(v);
        v = blank(); v.en0 = 1; v.e0 = mk(6, 0, 7, 0, 1, 0, 0);
        v.exp_word = mk(6, 0, 7, 0, 1, 1, 0); v.exp_free = 6; tbl.push_back(v);
        // wakeup and grant on the same slot both apply
        v = blank(); v.s0 = 1; v.n0 = 3'd0; v.wen = 4'b0010; v.wt[1] = 5'd6;
        v.exp_word = mk(6, 1, 7, 0, 1, 1, 1); v.exp_free = 6; tbl.push_back(v);
        // duplicate grant ignored; pending release still happens
        v = blank(); v.s0 = 1; v.n0 = 3'd0; v.s1 = 1; v.n1 = 3'd0;
        v.exp_word = '0; v.exp_free = 7; tbl.push_back(v);

        for (int r = 0; r < tbl.size(); r++) begin
            idle();
            rst = tbl[r].rst; flush = tbl[r].flush;
            disp_en0 = tbl[r].en0; disp_en1 = tbl[r].en1;
            disp_entry0 = tbl[r].e0; disp_entry1 = tbl[r].e1;
            wen = tbl[r].wen;
            for (int k = 0; k < 4; k++) wtag[k] = tbl[r].wt[k];
            sel_en0 = tbl[r].s0; sel_en1 = tbl[r].s1;
            sel_num0 = tbl[r].n0; sel_num1 = tbl[r].n1;
            tick();
            chk($sformatf("row%0d_free_count", r), 32'(free_count), 32'(tbl[r].exp_free));
            chk($sformatf("row%0d_disp_ready", r), 32'(disp_ready), 32'(tbl[r].exp_ready));
            chk($sformatf("row%0d_dout%0d", r, tbl[r].slot), 32'(dout_of(tbl[r].slot)),
                32'(tbl[r].exp_word));
        end

        // full queue: ready drops at one free slot, extra dispatch dropped
        idle(); rst = 1; tick();
        for (int p = 0; p < 3; p++) begin
            idle(); disp_en0 = 1; disp_en1 = 1;
            disp_entry0 = 21'($urandom); disp_entry1 = 21'($urandom);
            tick();
        end
        chk("full_free_count", 32'(free_count), 32'd1);
        chk("full_disp_ready", 32'(disp_ready), 32'd0);
        idle(); disp_en0 = 1; disp_entry0 = mk(1, 1, 1, 1, 1, 0, 0); tick();
        chk("full_drop_free_count", 32'(free_count), 32'd1);
        chk("full_drop_dout6", 32'(dq6), 32'd0);

        // flush mid-operation with concurrent dispatch, wakeup, grant
        idle(); flush = 1; disp_en0 = 1; disp_en1 = 1; disp_entry0 = 21'h1abcd;
        wen = 4'b1111; sel_en0 = 1; sel_num0 = 3'd2; tick();
        chk("flush_free_count", 32'(free_count), 32'd7);
        chk("flush_disp_ready", 32'(disp_ready), 32'd1);
        for (int i = 0; i < 7; i++) chk($sformatf("flush_dout%0d", i), 32'(dout_of(i)), 32'd0);

        // reset mid-operation
        idle(); disp_en0 = 1; disp_en1 = 1; disp_entry0 = 21'h0f0f0; disp_entry1 = 21'h0a0a0; tick();
        chk("pre_rst_free_count", 32'(free_count), 32'd5);
        idle(); rst = 1; disp_en0 = 1; disp_entry0 = 21'h12345; tick();
        chk("rst_free_count", 32'(free_count), 32'd7);
        chk("rst_dout0", 32'(dq0), 32'd0);

        // random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            int el[$];
            idle();
            for (int i = 0; i < 7; i++) if (mvalid[i] && !missued[i]) el.push_back(i);
            rst   = ($urandom_range(0, 299) == 0);
            flush = ($urandom_range(0, 49) == 0);
            disp_en0 = 1'($urandom_range(0, 1));
            disp_en1 = 1'($urandom_range(0, 1));
            disp_entry0 = 21'($urandom);
            disp_entry1 = 21'($urandom);
            disp_entry0[19:15] = 5'($urandom_range(0, 7)); disp_entry0[12:8] = 5'($urandom_range(0, 7));
            disp_entry1[19:15] = 5'($urandom_range(0, 7)); disp_entry1[12:8] = 5'($urandom_range(0, 7));
            wen = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            for (int k = 0; k < 4; k++) wtag[k] = 5'($urandom_range(0, 7));
            sel_en0 = ($urandom_range(0, 2) != 0);
            sel_en1 = ($urandom_range(0, 2) != 0);
            sel_num0 = (el.size() > 0 && $urandom_range(0, 4) != 0) ?
                       3'(el[$urandom_range(0, el.size() - 1)]) : 3'($urandom_range(0, 7));
            sel_num1 = (el.size() > 0 && $urandom_range(0, 4) != 0) ?
                       3'(el[$urandom_range(0, el.size() - 1)]) : 3'($urandom_range(0, 7));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
